// File: rtl/img2col_pkg.sv
// img2col_pkg
// Shared definitions for the img2col row-fetch path and its mapping control:
// default geometry of the image and line buffer, the width of the mapping
// fields, and the fetch FSM state encoding.
package img2col_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_KSIZE   = 3;
    localparam int DEF_IMG_W   = 32;
    localparam int DEF_IMG_H   = 32;
    localparam int DEF_MEM_AW  = 12;
    localparam int MAP_FIELD_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        HOLD
    } fetch_state_t;

    // Width of a counter that indexes n slots (never zero, so KSIZE=1 still works).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/img2col_win_reg.sv
// img2col_win_reg
// KSIZE-slot window capture register. Each slot has its own write enable;
// when pad is set the written slot is loaded with zero instead of wr_data.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears every slot
//   wr_en     one-hot (or zero) slot write enable
//   pad       write zero instead of wr_data
//   wr_data   pixel to store
//   win_data  all slots, slot k at bits [k*DATA_W +: DATA_W]
module img2col_win_reg
    import img2col_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KSIZE  = DEF_KSIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KSIZE-1:0]          wr_en,
    input  logic                      pad,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [KSIZE*DATA_W-1:0]   win_data
);

    // Slot storage; only the enabled slot changes on a given edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_data <= '0;
        end else begin
            for (int i = 0; i < KSIZE; i++) begin
                if (wr_en[i]) begin
                    win_data[i*DATA_W +: DATA_W] <= pad ? '0 : wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/img2col_row_fetch.sv
// img2col_row_fetch
// Fetches one KSIZE-pixel window from a row of the line buffer for a PU.
// A mapping request (row, start column, PU, round) is latched in IDLE, the
// KSIZE pixels are read one per cycle, out-of-image pixels are zero padded
// without touching memory, and the finished window is held until the PU
// loader takes it.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   map_valid / map_ready    mapping request handshake
//   map_round, map_pu1_add,  request fields, sampled only on acceptance
//   map_pu_no, map_row_no
//   mem_rd_en, mem_rd_addr   line-buffer read port
//   mem_rd_data              read data, valid one cycle after mem_rd_en
//   win_valid / win_ready    window handshake towards the PU loader
//   win_data                 window, element k at bits [k*DATA_W +: DATA_W]
//   win_pu, win_row,         fields of the request that produced the window
//   win_round
module img2col_row_fetch
    import img2col_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KSIZE  = DEF_KSIZE,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int MEM_AW = DEF_MEM_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     map_valid,
    output logic                     map_ready,
    input  logic [5:0]               map_round,
    input  logic [5:0]               map_pu1_add,
    input  logic [5:0]               map_pu_no,
    input  logic [5:0]               map_row_no,
    output logic                     mem_rd_en,
    output logic [MEM_AW-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [KSIZE*DATA_W-1:0]  win_data,
    output logic [5:0]               win_pu,
    output logic [5:0]               win_row,
    output logic [5:0]               win_round
);

    localparam int K_W = cnt_width(KSIZE);
    localparam logic [K_W-1:0] K_LAST = K_W'(KSIZE - 1);

    fetch_state_t state, state_next;

    logic [5:0]        pu1_q;
    logic [K_W-1:0]    k;
    logic              issue_pad;
    logic [MEM_AW-1:0] issue_addr;

    // Issue-to-capture pipeline: describes the element whose data is on
    // mem_rd_data this cycle.
    logic              cap_valid;
    logic [K_W-1:0]    cap_slot;
    logic              cap_pad;
    logic [KSIZE-1:0]  slot_wr_en;

    // Column past the row end or row past the image bottom means padding.
    always_comb begin
        issue_pad  = ((int'(pu1_q) + int'(k)) >= IMG_W) || (int'(win_row) >= IMG_H);
        issue_addr = MEM_AW'(win_row) * MEM_AW'(IMG_W) + MEM_AW'(pu1_q) + MEM_AW'(k);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake / memory strobes; memory is only touched in
    // READ for in-image elements.
    always_comb begin
        state_next  = state;
        map_ready   = 1'b0;
        win_valid   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state)
            IDLE: begin
                map_ready = 1'b1;
                if (map_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (!issue_pad) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = issue_addr;
                end
                if (k == K_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = HOLD;
            end
            HOLD: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are latched only on acceptance so they stay stable
    // through READ and HOLD regardless of what mapping control does next.
    always_ff @(posedge clk) begin
        if (rst) begin
            pu1_q     <= '0;
            win_pu    <= '0;
            win_row   <= '0;
            win_round <= '0;
        end else if (state == IDLE && map_valid) begin
            pu1_q     <= map_pu1_add;
            win_pu    <= map_pu_no;
            win_row   <= map_row_no;
            win_round <= map_round;
        end
    end

    // Element counter: held at zero while idle, advances once per READ cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
        end else if (state == IDLE) begin
            k <= '0;
        end else if (state == READ) begin
            k <= k + 1'b1;
        end
    end

    // Delay the issue information by one cycle to line it up with the
    // read data; a reset drops any element still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_slot  <= '0;
            cap_pad   <= 1'b0;
        end else begin
            cap_valid <= (state == READ);
            cap_slot  <= k;
            cap_pad   <= issue_pad;
        end
    end

    always_comb begin
        slot_wr_en = '0;
        for (int i = 0; i < KSIZE; i++) begin
            slot_wr_en[i] = cap_valid && (cap_slot == K_W'(i));
        end
    end

    img2col_win_reg #(
        .DATA_W (DATA_W),
        .KSIZE  (KSIZE)
    ) u_win_reg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (slot_wr_en),
        .pad      (cap_pad),
        .wr_data  (mem_rd_data),
        .win_data (win_data)
    );

endmodule

// File: tb/tb_img2col_row_fetch.sv
// tb_img2col_row_fetch
// Directed bench for img2col_row_fetch with default parameters. The line
// buffer model returns the low address byte one cycle after mem_rd_en and
// 8'hEE otherwise, so any unpadded element that skipped memory is visible.
// Cycle numbering inside each test: cycle 0 is the cycle where map_valid is
// presented and accepted; the window is expected in cycle 5.
module tb_img2col_row_fetch;

    localparam int DATA_W = 8;
    localparam int KSIZE  = 3;
    localparam int MEM_AW = 12;

    logic                    clk;
    logic                    rst;
    logic                    map_valid;
    logic                    map_ready;
    logic [5:0]              map_round;
    logic [5:0]              map_pu1_add;
    logic [5:0]              map_pu_no;
    logic [5:0]              map_row_no;
    logic                    mem_rd_en;
    logic [MEM_AW-1:0]       mem_rd_addr;
    logic [DATA_W-1:0]       mem_rd_data;
    logic                    win_valid;
    logic                    win_ready;
    logic [KSIZE*DATA_W-1:0] win_data;
    logic [5:0]              win_pu;
    logic [5:0]              win_row;
    logic [5:0]              win_round;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_total = 0;
    int wv_total = 0;
    int rd_base = 0;
    int wv_base = 0;
    logic [MEM_AW-1:0] rd_hist [64];

    img2col_row_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .map_valid   (map_valid),
        .map_ready   (map_ready),
        .map_round   (map_round),
        .map_pu1_add (map_pu1_add),
        .map_pu_no   (map_pu_no),
        .map_row_no  (map_row_no),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_pu      (win_pu),
        .win_row     (win_row),
        .win_round   (win_round)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line buffer model (buffer[i] = i & 0xFF) plus read / valid logging.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_rd_addr[7:0] : 8'hEE;
        if (mem_rd_en) begin
            rd_hist[rd_total % 64] <= mem_rd_addr;
            rd_total <= rd_total + 1;
        end
        if (win_valid) begin
            wv_total <= wv_total + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request in cycle 0 and returns in cycle 1 with the map
    // fields scrambled, so anything not latched on acceptance shows up.
    task automatic issue_req(input logic [5:0] rnd, input logic [5:0] pu1,
                             input logic [5:0] pu, input logic [5:0] row);
        map_valid   = 1'b1;
        map_round   = rnd;
        map_pu1_add = pu1;
        map_pu_no   = pu;
        map_row_no  = row;
        rd_base     = rd_total;
        step(1);
        map_valid   = 1'b0;
        map_round   = 6'h3F;
        map_pu1_add = 6'h3F;
        map_pu_no   = 6'h3F;
        map_row_no  = 6'h3F;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        map_valid = 1'b0;
        win_ready = 1'b0;
        map_round = '0; map_pu1_add = '0; map_pu_no = '0; map_row_no = '0;
        step(2);
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_map_ready: got %b want 1", map_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_win_valid: got %b want 0", win_valid); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rd_en: got %b want 0", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 12'd0) begin n_bad++; $display("[TB] FAIL reset_rd_addr: got %0d want 0", mem_rd_addr); end
        n_cmp++; if (win_data !== 24'h0) begin n_bad++; $display("[TB] FAIL reset_win_data: got %h want 000000", win_data); end
        n_cmp++; if (win_pu !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_win_pu: got %0d want 0", win_pu); end
        n_cmp++; if (win_row !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_win_row: got %0d want 0", win_row); end
        n_cmp++; if (win_round !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_win_round: got %0d want 0", win_round); end
        rst = 1'b0;
        step(1);
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_map_ready: got %b want 1", map_ready); end
    endtask

    // Row 2, start column 5: addresses 69..71.
    task automatic test_basic_window();
        issue_req(6'd3, 6'd5, 6'd7, 6'd2);
        n_cmp++; if (map_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_busy_ready: got %b want 0", map_ready); end
        n_cmp++; if (mem_rd_en !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_first_rd_en: got %b want 1", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 12'd69) begin n_bad++; $display("[TB] FAIL basic_first_addr: got %0d want 69", mem_rd_addr); end
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_early_valid cycle %0d: got %b want 0", c, win_valid); end
            step(1);
        end
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_valid_cycle5: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'h474645) begin n_bad++; $display("[TB] FAIL basic_win_data: got %h want 474645", win_data); end
        n_cmp++; if (win_pu !== 6'd7) begin n_bad++; $display("[TB] FAIL basic_win_pu: got %0d want 7", win_pu); end
        n_cmp++; if (win_row !== 6'd2) begin n_bad++; $display("[TB] FAIL basic_win_row: got %0d want 2", win_row); end
        n_cmp++; if (win_round !== 6'd3) begin n_bad++; $display("[TB] FAIL basic_win_round: got %0d want 3", win_round); end
        n_cmp++; if (rd_total - rd_base !== 3) begin n_bad++; $display("[TB] FAIL basic_rd_count: got %0d want 3", rd_total - rd_base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_hist[(rd_base + i) % 64] !== MEM_AW'(69 + i)) begin n_bad++; $display("[TB] FAIL basic_rd_addr %0d: got %0d want %0d", i, rd_hist[(rd_base + i) % 64], 69 + i); end
        end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_valid_drop: got %b want 0", win_valid); end
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_ready_back: got %b want 1", map_ready); end
    endtask

    // Start column 30 of 32: third element is padding and never read.
    task automatic test_right_edge();
        issue_req(6'd1, 6'd30, 6'd4, 6'd0);
        n_cmp++; if (mem_rd_en !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_rd_en_k0: got %b want 1", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 12'd30) begin n_bad++; $display("[TB] FAIL edge_addr_k0: got %0d want 30", mem_rd_addr); end
        step(2);
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_rd_en_k2: got %b want 0", mem_rd_en); end
        step(2);
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'h001F1E) begin n_bad++; $display("[TB] FAIL edge_win_data: got %h want 001f1e", win_data); end
        n_cmp++; if (rd_total - rd_base !== 2) begin n_bad++; $display("[TB] FAIL edge_rd_count: got %0d want 2", rd_total - rd_base); end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
    endtask

    // Row 40 is below the image: all three elements padded, no reads.
    task automatic test_row_out_of_range();
        issue_req(6'd2, 6'd0, 6'd5, 6'd40);
        step(4);
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL oor_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'h0) begin n_bad++; $display("[TB] FAIL oor_win_data: got %h want 000000", win_data); end
        n_cmp++; if (rd_total - rd_base !== 0) begin n_bad++; $display("[TB] FAIL oor_rd_count: got %0d want 0", rd_total - rd_base); end
        n_cmp++; if (win_row !== 6'd40) begin n_bad++; $display("[TB] FAIL oor_win_row: got %0d want 40", win_row); end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
    endtask

    // Window held 10 cycles with a competing request pending; that request
    // is taken right after the release.
    task automatic test_hold_stall();
        issue_req(6'd12, 6'd0, 6'd9, 6'd1);
        step(4);
        map_valid   = 1'b1;
        map_round   = 6'd4;
        map_pu1_add = 6'd1;
        map_pu_no   = 6'd2;
        map_row_no  = 6'd5;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_valid %0d: got %b want 1", c, win_valid); end
            n_cmp++; if (win_data !== 24'h222120) begin n_bad++; $display("[TB] FAIL stall_data %0d: got %h want 222120", c, win_data); end
            n_cmp++; if (win_pu !== 6'd9) begin n_bad++; $display("[TB] FAIL stall_pu %0d: got %0d want 9", c, win_pu); end
            n_cmp++; if (map_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_map_ready %0d: got %b want 0", c, map_ready); end
            step(1);
        end
        n_cmp++; if (rd_total - rd_base !== 3) begin n_bad++; $display("[TB] FAIL stall_rd_count: got %0d want 3", rd_total - rd_base); end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_release_ready: got %b want 1", map_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_release_valid: got %b want 0", win_valid); end
        rd_base = rd_total;
        step(1);
        map_valid = 1'b0;
        map_round = 6'h3F; map_pu1_add = 6'h3F; map_pu_no = 6'h3F; map_row_no = 6'h3F;
        step(4);
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_second_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'hA3A2A1) begin n_bad++; $display("[TB] FAIL stall_second_data: got %h want a3a2a1", win_data); end
        n_cmp++; if (win_pu !== 6'd2) begin n_bad++; $display("[TB] FAIL stall_second_pu: got %0d want 2", win_pu); end
        n_cmp++; if (win_row !== 6'd5) begin n_bad++; $display("[TB] FAIL stall_second_row: got %0d want 5", win_row); end
        n_cmp++; if (win_round !== 6'd4) begin n_bad++; $display("[TB] FAIL stall_second_round: got %0d want 4", win_round); end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
    endtask

    // win_ready held high from the start: early ready changes nothing and
    // requests run at the minimum 6-cycle period.
    task automatic test_back_to_back();
        win_ready = 1'b1;
        issue_req(6'd7, 6'd20, 6'd11, 6'd10);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_early_valid cycle %0d: got %b want 0", c, win_valid); end
            step(1);
        end
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_first_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'h565554) begin n_bad++; $display("[TB] FAIL b2b_first_data: got %h want 565554", win_data); end
        step(1);
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_valid_drop: got %b want 0", win_valid); end
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_ready_cycle6: got %b want 1", map_ready); end
        issue_req(6'd8, 6'd0, 6'd12, 6'd31);
        step(4);
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_second_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'hE2E1E0) begin n_bad++; $display("[TB] FAIL b2b_second_data: got %h want e2e1e0", win_data); end
        n_cmp++; if (win_round !== 6'd8) begin n_bad++; $display("[TB] FAIL b2b_second_round: got %0d want 8", win_round); end
        step(1);
        win_ready = 1'b0;
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_second_drop: got %b want 0", win_valid); end
    endtask

    // Reset in the k=1 READ cycle drops the window; a new request still works.
    task automatic test_reset_mid();
        issue_req(6'd9, 6'd0, 6'd3, 6'd3);
        step(1);
        n_cmp++; if (mem_rd_addr !== 12'd97) begin n_bad++; $display("[TB] FAIL mid_addr_k1: got %0d want 97", mem_rd_addr); end
        rst = 1'b1;
        wv_base = wv_total;
        step(1);
        rst = 1'b0;
        n_cmp++; if (map_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_map_ready: got %b want 1", map_ready); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_rd_en: got %b want 0", mem_rd_en); end
        n_cmp++; if (win_data !== 24'h0) begin n_bad++; $display("[TB] FAIL mid_win_data: got %h want 000000", win_data); end
        step(8);
        n_cmp++; if (wv_total - wv_base !== 0) begin n_bad++; $display("[TB] FAIL mid_no_valid: got %0d valid cycles want 0", wv_total - wv_base); end
        issue_req(6'd10, 6'd10, 6'd13, 6'd0);
        step(4);
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_fresh_valid: got %b want 1", win_valid); end
        n_cmp++; if (win_data !== 24'h0C0B0A) begin n_bad++; $display("[TB] FAIL mid_fresh_data: got %h want 0c0b0a", win_data); end
        n_cmp++; if (win_pu !== 6'd13) begin n_bad++; $display("[TB] FAIL mid_fresh_pu: got %0d want 13", win_pu); end
        win_ready = 1'b1;
        step(1);
        win_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] img2col_row_fetch directed test start");
        test_reset();
        test_basic_window();
        test_right_edge();
        test_row_out_of_range();
        test_hold_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/img2col_row_fetch.md
IMG2COL_ROW_FETCH -- requirements
Module: img2col_row_fetch

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter KSIZE, default 3: pixels per window (kernel width).
REQ-003 Parameter IMG_W, default 32: image row length in pixels.
REQ-004 Parameter IMG_H, default 32: image rows.
REQ-005 Parameter MEM_AW, default 12: line-buffer address width.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- map_valid  in  1  mapping-control fields valid.
- map_ready  out  1  block accepts a new mapping request.
- map_round  in  6  current round from mapping control.
- map_pu1_add  in  6  start column for this window.
- map_pu_no  in  6  target PU index.
- map_row_no  in  6  image row index.
- mem_rd_en  out  1  line-buffer read strobe.
- mem_rd_addr  out  MEM_AW  line-buffer read address.
- mem_rd_data  in  DATA_W  read data; valid exactly 1 cycle after mem_rd_en.
- win_valid  out  1  window output valid.
- win_ready  in  1  downstream PU loader accepts window.
- win_data  out  KSIZE*DATA_W  window; element k at bits [k*DATA_W +: DATA_W].
- win_pu  out  6  latched map_pu_no.
- win_row  out  6  latched map_row_no.
- win_round  out  6  latched map_round.

Function
REQ-007 FSM states IDLE, READ, DRAIN, HOLD; map_ready=1 only in IDLE.
REQ-008 IDLE: on map_valid=1 latch all four map_* fields, clear k counter, go READ.
REQ-009 READ: each cycle issue element k, k=0..KSIZE-1; after k=KSIZE-1 go DRAIN.
REQ-010 Element address = map_row_no*IMG_W + map_pu1_add + k, computed at MEM_AW bits, no truncation for legal parameters.
REQ-011 If map_pu1_add+k >= IMG_W or map_row_no >= IMG_H: mem_rd_en=0 for that cycle and element k captured as zero (padding).
REQ-012 Element k captured into window slot k one cycle after its issue cycle (READ or DRAIN cycle).
REQ-013 DRAIN: capture last element, go HOLD.
REQ-014 HOLD: win_valid=1; win_data/win_pu/win_row/win_round stable until win_ready=1; on win_valid&win_ready go IDLE.
REQ-015 Latency: win_valid rises KSIZE+2 cycles after the map accept edge; minimum request period KSIZE+3 cycles.
REQ-016 map_valid while not in IDLE is ignored; fields are not sampled.
REQ-017 win_ready while not in HOLD has no effect.
REQ-018 mem_rd_en=0 in IDLE, DRAIN, HOLD.

Reset
REQ-019 rst=1 at a clock edge: state IDLE, k=0, window cleared to 0, win_valid=0, mem_rd_en=0, mem_rd_addr=0, win_pu/win_row/win_round=0; map_ready=1 from the first cycle after reset.
REQ-020 Reset mid-operation discards the in-flight window; no win_valid pulse follows.

Structure
REQ-021 Package img2col_pkg holds DATA_W, KSIZE, IMG_W, IMG_H, MEM_AW defaults and the FSM state enum; shared with mapping control.
REQ-022 One sub-module, img2col_win_reg: KSIZE-slot capture register with per-slot write enable and zero-pad input.

Verification
REQ-023 Row 2, pu1_add 5, buffer[i]=i&0xFF: reads 69,70,71; win_data={71,70,69}; win_valid at accept+5.
REQ-024 pu1_add 30, IMG_W 32: reads 30,31 only; element 2 = 0; no mem_rd_en in third READ cycle.
REQ-025 row_no 40 (>= IMG_H): zero mem_rd_en pulses; win_data = 0; win_valid still asserted.
REQ-026 win_ready held 0 for 10 cycles in HOLD: outputs stable; map_ready=0; second map_valid ignored; accepted after release.
REQ-027 rst=1 during READ k=1: next cycle IDLE, map_ready=1, no win_valid; a fresh request completes normally.
